// File: rtl/prince_iter_core.sv
// prince_iter_core
// Iterative PRINCE block cipher (64-bit block, 128-bit key) with run-time
// encrypt/decrypt selection. Decryption uses the alpha-reflection property,
// so one forward/middle/backward datapath serves both directions; only the
// whitening and core keys loaded at acceptance differ.
//
// Parameter
//   UNROLL     rounds per cycle in the forward and backward halves (1 or 5)
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   request carries a block
//   in_ready   core accepts a block this cycle (IDLE only)
//   decrypt    0 = encrypt, 1 = decrypt, sampled with the block
//   data_in    plaintext or ciphertext block
//   key        {k0, k1}, sampled with the block
//   out_valid  data_out holds a finished result
//   out_ready  consumer takes the result
//   data_out   result block
module prince_iter_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         decrypt,
  input  logic [63:0]  data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out
);

  localparam int          ROUNDS_HALF  = 5;
  localparam logic [63:0] ALPHA        = 64'hc0ac29b7c97c50dd;
  // Nibble n of each table holds S(n) / S^-1(n).
  localparam logic [63:0] SBOX_TAB     = 64'h4D5E087619CA23FB;
  localparam logic [63:0] SBOX_INV_TAB = 64'h1CE5046A98DF237B;

  if (UNROLL != 1 && UNROLL != 5) begin : g_bad_unroll
    $error("prince_iter_core: UNROLL must be 1 or 5");
  end

  typedef enum logic [2:0] {IDLE, FWD, MID, BWD, HOLD} fsm_e;

  function automatic logic [63:0] round_const(input logic [3:0] idx);
    logic [63:0] rc;
    case (idx)
      4'd1:    rc = 64'h13198a2e03707344;
      4'd2:    rc = 64'ha4093822299f31d0;
      4'd3:    rc = 64'h082efa98ec4e6c89;
      4'd4:    rc = 64'h452821e638d01377;
      4'd5:    rc = 64'hbe5466cf34e90c6c;
      4'd6:    rc = 64'h7ef84f78fd955cb1;
      4'd7:    rc = 64'h85840851f1ac43aa;
      4'd8:    rc = 64'hc882d32f25323c54;
      4'd9:    rc = 64'h64a51195e0e3610d;
      4'd10:   rc = 64'hd3b5a399ca0c2399;
      4'd11:   rc = 64'hc0ac29b7c97c50dd;
      default: rc = 64'h0;
    endcase
    return rc;
  endfunction

  function automatic logic [63:0] sub_nibbles(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    logic [63:0] tab;
    y   = '0;
    tab = inv ? SBOX_INV_TAB : SBOX_TAB;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = tab[{x[4*n +: 4], 2'b00} +: 4];
    return y;
  endfunction

  // M' = diag(M^0, M^1, M^1, M^0) over 16-bit chunks, an involution.
  // Inside a chunk, output nibble j bit b is the XOR of bit b of every input
  // nibble except one; the skipped nibble follows the circulant layout of
  // the block (indices LSB-first).
  function automatic logic [63:0] m_prime(input logic [63:0] x);
    logic [63:0] y;
    int          skip;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        for (int b = 0; b < 4; b++) begin
          skip = (c == 0 || c == 3) ? ((b - j + 3) & 3) : ((b - j) & 3);
          for (int k = 0; k < 4; k++) begin
            if (k != skip) y[16*c + 4*j + b] = y[16*c + 4*j + b] ^ x[16*c + 4*k + b];
          end
        end
      end
    end
    return y;
  endfunction

  // AES-style row shift; nibble 0 is the most significant. Output nibble i
  // takes input nibble 5i mod 16 (forward) or 13i mod 16 (inverse).
  function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    int          src;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      src = inv ? ((13 * i) % 16) : ((5 * i) % 16);
      y[4*(15-i) +: 4] = x[4*(15-src) +: 4];
    end
    return y;
  endfunction

  function automatic logic [63:0] fwd_round(input logic [63:0] x, input logic [63:0] rc,
                                            input logic [63:0] k);
    return shift_rows(m_prime(sub_nibbles(x, 1'b0)), 1'b0) ^ rc ^ k;
  endfunction

  function automatic logic [63:0] bwd_round(input logic [63:0] x, input logic [63:0] rc,
                                            input logic [63:0] k);
    return sub_nibbles(m_prime(shift_rows(x ^ k ^ rc, 1'b1)), 1'b1);
  endfunction

  fsm_e        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [63:0] kout_q, kout_d;
  logic [63:0] kc_q, kc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] data_out_q, data_out_d;
  logic        out_valid_q, out_valid_d;

  logic [63:0] k0, k1, k0_prime;
  logic [63:0] kin, kout_in, kc_in;
  logic [63:0] fwd_x, bwd_x;
  logic        accept, half_done;

  assign k0       = key[127:64];
  assign k1       = key[63:0];
  assign k0_prime = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};
  // Alpha reflection: swap the whitening keys and offset the core key.
  assign kin      = decrypt ? k0_prime : k0;
  assign kout_in  = decrypt ? k0 : k0_prime;
  assign kc_in    = decrypt ? (k1 ^ ALPHA) : k1;

  // Held low during reset so no block is taken while the core is cleared.
  assign in_ready  = (fsm_q == IDLE) && reset;
  assign accept    = in_valid && in_ready;
  assign half_done = (cnt_q + 3'(UNROLL)) == 3'(ROUNDS_HALF);
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    fsm_d       = fsm_q;
    state_d     = state_q;
    kout_d      = kout_q;
    kc_d        = kc_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;

    fwd_x = state_q;
    bwd_x = state_q;
    for (int u = 0; u < UNROLL; u++) begin
      fwd_x = fwd_round(fwd_x, round_const(4'(cnt_q) + 4'(u) + 4'd1), kc_q);
      bwd_x = bwd_round(bwd_x, round_const(4'(cnt_q) + 4'(u) + 4'd6), kc_q);
    end

    case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d = data_in ^ kin ^ kc_in ^ round_const(4'd0);
          kout_d  = kout_in;
          kc_d    = kc_in;
          cnt_d   = '0;
          fsm_d   = FWD;
        end
      end
      FWD: begin
        state_d = fwd_x;
        if (half_done) begin
          cnt_d = '0;
          fsm_d = MID;
        end else begin
          cnt_d = cnt_q + 3'(UNROLL);
        end
      end
      MID: begin
        state_d = sub_nibbles(m_prime(sub_nibbles(state_q, 1'b0)), 1'b1);
        fsm_d   = BWD;
      end
      BWD: begin
        state_d = bwd_x;
        if (half_done) begin
          cnt_d       = '0;
          data_out_d  = bwd_x ^ round_const(4'd11) ^ kc_q ^ kout_q;
          out_valid_d = 1'b1;
          fsm_d       = HOLD;
        end else begin
          cnt_d = cnt_q + 3'(UNROLL);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so key material and partial
  // state never survive an aborted operation and data_out reads 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      kout_q      <= '0;
      kc_q        <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      kout_q      <= kout_d;
      kc_q        <= kc_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_prince_iter_core.sv
// Self-checking bench for prince_iter_core. Two instances (UNROLL=1 and
// UNROLL=5) share the data/key/decrypt inputs and are exercised one at a
// time. Expected results are queued when a block is driven and compared
// when the DUT presents its output.
module tb_prince_iter_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [63:0]  data_out  [2];
  logic         decrypt;
  logic [63:0]  data_in;
  logic [127:0] key;

  logic [63:0]  exp_q [$];
  int           n_checks = 0;
  int           n_errors = 0;

  logic [63:0]  vec_pt  [5] = '{64'h0, 64'hffffffffffffffff, 64'h0, 64'h0,
                                64'h0123456789abcdef};
  logic [127:0] vec_key [5] = '{128'h0, 128'h0,
                                {64'hffffffffffffffff, 64'h0},
                                {64'h0, 64'hffffffffffffffff},
                                {64'h0, 64'hfedcba9876543210}};
  logic [63:0]  vec_ct  [5] = '{64'h818665aa0d02dfda, 64'h604ae6ca03c20ada,
                                64'h9fb51935fc3df524, 64'h78a54cbe737bb7ef,
                                64'hae25ad3ca8fa9ccf};

  always #5 clk = ~clk;

  prince_iter_core #(.UNROLL(1)) u_dut_u1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .decrypt(decrypt), .data_in(data_in), .key(key),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .data_out(data_out[0])
  );

  prince_iter_core #(.UNROLL(5)) u_dut_u5 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .decrypt(decrypt), .data_in(data_in), .key(key),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .data_out(data_out[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // in_ready and out_valid must never be high together.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++)
      check($sformatf("excl_u%0d", s), 64'(in_ready[s] && out_valid[s]), 64'd0);
  end

  // One transaction on instance sel. Called just after a rising edge.
  // hold > 0: out_ready stays low for hold cycles after out_valid rises while
  // in_valid is asserted. toggle: inputs flip every cycle during processing.
  task automatic run_op(input int sel, input logic [63:0] din, input logic [127:0] k,
                        input logic dec, input logic [63:0] exp, input int hold,
                        input bit toggle);
    int          n;
    int          lat;
    logic [63:0] exp_v;
    lat = (sel == 0) ? 11 : 3;
    exp_q.push_back(exp);
    data_in        = din;
    key            = k;
    decrypt        = dec;
    out_ready[sel] = (hold == 0);
    in_valid[sel]  = 1'b1;
    n = 0;
    while (!in_ready[sel] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("accept_rdy_u%0d", sel), 64'(in_ready[sel]), 64'd1);
    @(posedge clk); #1;
    if (!toggle) in_valid[sel] = 1'b0;
    n = 0;
    while (!out_valid[sel] && n < 100) begin
      if (toggle) begin
        data_in = ~data_in;
        key     = ~key;
        decrypt = ~decrypt;
      end
      @(posedge clk); #1; n++;
    end
    in_valid[sel] = 1'b0;
    check($sformatf("latency_u%0d", sel), 64'(n), 64'(lat));
    exp_v = 64'h0;
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    check($sformatf("data_u%0d_dec%0d", sel, dec), data_out[sel], exp_v);
    for (int c = 0; c < hold; c++) begin
      in_valid[sel] = 1'b1;
      data_in       = ~data_in;
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid[sel]), 64'd1);
      check("hold_data", data_out[sel], exp_v);
      check("hold_rdy", 64'(in_ready[sel]), 64'd0);
    end
    in_valid[sel]  = 1'b0;
    out_ready[sel] = 1'b1;
    @(posedge clk); #1;
    check($sformatf("valid_fall_u%0d", sel), 64'(out_valid[sel]), 64'd0);
    check($sformatf("rdy_back_u%0d", sel), 64'(in_ready[sel]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    decrypt = 1'b0;
    data_in = '0;
    key     = '0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b1;
    end
    #1 reset = 1'b0;
    #2;
    for (int s = 0; s < 2; s++) begin
      check("rst_in_ready", 64'(in_ready[s]), 64'd0);
      check("rst_out_valid", 64'(out_valid[s]), 64'd0);
      check("rst_data_out", data_out[s], 64'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) check("post_rst_rdy", 64'(in_ready[s]), 64'd1);

    // Reference vectors, encrypt then decrypt, on both unroll factors.
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 5; v++) begin
        run_op(s, vec_pt[v], vec_key[v], 1'b0, vec_ct[v], 0, 1'b0);
        run_op(s, vec_ct[v], vec_key[v], 1'b1, vec_pt[v], 0, 1'b0);
      end
    end

    // Backpressure: 20 cycles with out_ready low and in_valid high.
    run_op(0, vec_pt[1], vec_key[1], 1'b0, vec_ct[1], 20, 1'b0);

    // Input isolation: inputs toggle every cycle after acceptance.
    run_op(0, vec_pt[4], vec_key[4], 1'b0, vec_ct[4], 0, 1'b1);
    run_op(1, vec_ct[3], vec_key[3], 1'b1, vec_pt[3], 0, 1'b1);

    // Reset five cycles into an encryption.
    out_ready[0] = 1'b1;
    data_in      = vec_pt[0];
    key          = vec_key[0];
    decrypt      = 1'b0;
    in_valid[0]  = 1'b1;
    check("mid_rst_pre_rdy", 64'(in_ready[0]), 64'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid[0]), 64'd0);
    check("mid_rst_data", data_out[0], 64'h0);
    check("mid_rst_rdy", 64'(in_ready[0]), 64'd0);
    @(posedge clk); #1;
    check("mid_rst_rdy_held", 64'(in_ready[0]), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rdy_after", 64'(in_ready[0]), 64'd1);
    check("mid_rst_valid_after", 64'(out_valid[0]), 64'd0);
    run_op(0, vec_pt[0], vec_key[0], 1'b0, vec_ct[0], 0, 1'b0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prince_iter_core.md
# prince_iter_core

Iterative PRINCE block-cipher core (64-bit block, 128-bit key) with a run-time encrypt/decrypt mode, a valid/ready handshake on both sides and a compile-time unroll factor. It is the next-generation successor to the fixed round-based `prince_top` datapath. It also sits behind the same top-level plaintext/key/ciphertext path, but adds:

- flow control;
- decryption through the PRINCE alpha-reflection property;
- a selectable throughput/area trade-off.

## Interface
- UNROLL, 1, rounds computed per cycle in the forward and backward halves; legal values 1 or 5, any other value is an elaboration error
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  request carries a block
- in_ready  output  1  core accepts a block this cycle
- decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with the block
- data_in  input  64  plaintext (or ciphertext when decrypt=1)
- key  input  128  key[127:64]=k0, key[63:0]=k1; sampled with the block
- out_valid  output  1  data_out holds a finished result
- out_ready  input  1  consumer takes the result
- data_out  output  64  result block

## Operation
- k0' = (k0 ror 1) xor (k0 >> 63). alpha = 64'hc0ac29b7c97c50dd. RC0..RC11, the S-box, S^-1, M and M' follow the PRINCE specification.
- Encrypt uses kin=k0, kout=k0', kc=k1. Decrypt uses kin=k0', kout=k0, kc=k1 xor alpha. The datapath is identical in both modes.
- Acceptance is `in_valid && in_ready`.
- On acceptance the core registers:
  - state ← data_in xor kin xor kc xor RC0;
  - kout and kc, held for the whole operation;
  - the round counter, cleared to 0.
- FSM states: IDLE, FWD, MID, BWD, HOLD.
- IDLE:
  - in_ready=1;
  - goes to FWD on acceptance.
- FWD:
  - each cycle applies UNROLL forward rounds, where round i is state ← M(S(state)) xor RC_i xor kc;
  - i runs 1..5;
  - counter increments by UNROLL and wraps to 0 on leaving;
  - goes to MID once 5 rounds are done.
- MID:
  - one cycle, state ← S^-1(M'(S(state)));
  - goes to BWD.
- BWD:
  - each cycle applies UNROLL inverse rounds, where round i is state ← S^-1(M^-1(state xor kc xor RC_i));
  - i runs 6..10.
  - On the last BWD cycle:
    - data_out ← S^-1(M^-1(state xor kc xor RC10)) xor RC11 xor kc xor kout;
    - out_valid ← 1;
    - goes to HOLD.
- HOLD:
  - data_out and out_valid stay stable until out_ready=1;
  - on that edge out_valid ← 0 and the FSM goes to IDLE.
- in_ready is 1 only in IDLE. in_valid is ignored in any other state, and no request is queued.
- Changes to data_in, key or decrypt after acceptance have no effect.
- The M matrix reuses the same M' plus shift-rows logic in both directions. The inverse shift-rows is the only difference.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system) clears the following, effective immediately including mid-operation:
  - FSM state to IDLE;
  - in_ready=1 after reset;
  - out_valid=0;
  - data_out=64'h0;
  - state, keys and counter to 0.
- Latency L = 2*(5/UNROLL)+1, counted from the acceptance edge to the edge that sets out_valid. L=11 for UNROLL=1 and L=3 for UNROLL=5.
- out_valid is high from the cycle after that edge.
- With out_ready tied high:
  - out_valid is a 1-cycle pulse;
  - in_ready rises the cycle after the pulse;
  - minimum issue interval is L+2 cycles.
- If out_ready is already high when out_valid rises, the result is consumed on the next edge.
- There is no combinational path from in_valid, out_ready or data_in to any output.
- in_ready and out_valid are never high in the same cycle.

## Test plan
- Encrypt, data_in=0, key=0 → data_out=64'h818665aa0d02dfda, out_valid 11 cycles after acceptance (UNROLL=1) and 3 cycles after acceptance (UNROLL=5).
- Encrypt the other reference vectors, with key given as k0|k1:
  - data_in=all-ones, key=0 → 64'h604ae6ca03c20ada;
  - data_in=0, key=all-ones|0 → 64'h9fb51935fc3df524;
  - data_in=0, key=0|all-ones → 64'h78a54cbe737bb7ef;
  - data_in=64'h0123456789abcdef, key=0|64'hfedcba9876543210 → 64'hae25ad3ca8fa9ccf.
- Decrypt each ciphertext above with decrypt=1 and the same key → the original plaintext.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid rises → data_out stable, out_valid=1, and in_ready=0 even with in_valid=1. Raise out_ready → out_valid falls next edge, and in_ready=1 the cycle after.
- Input isolation: accept a block, then toggle data_in, key and decrypt every cycle during processing → result equals the vector for the sampled values, with no second acceptance.
- Reset mid-operation: pull reset low 5 cycles into an encryption → out_valid=0, data_out=0 and in_ready=0 while reset is low. After release, in_ready=1 and a fresh encryption of vector 1 returns 64'h818665aa0d02dfda.
